// File: rtl/mr_retire_pkg.sv
// Shared types and default sizing for the in-order retire-queue controller.
package mr_retire_pkg;

   localparam int unsigned RQ_DEPTH = 8;
   localparam int unsigned RQ_NREQ  = 2;
   localparam int unsigned RQ_PCW   = 32;
   localparam int unsigned RQ_IDW   = $clog2(RQ_DEPTH);

   typedef logic [RQ_IDW-1:0] inst_id_t;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              exc;
      logic [RQ_PCW-1:0] pc;
   } rq_entry_t;

endpackage

// File: rtl/mr_rr_arb.sv
// Round-robin arbiter: one-hot grant among requesters, search starts at the pointer.
module mr_rr_arb #(
   parameter  int unsigned N = 2,
   localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         any,
   output logic [W-1:0] idx
);

   logic [W-1:0] ptr;
   logic [W-1:0] ptr_nxt;
   int unsigned  cand;

   // First requester at or after the pointer wins; pointer moves past the winner.
   always_comb begin
      gnt     = '0;
      any     = 1'b0;
      idx     = '0;
      ptr_nxt = ptr;
      cand    = 0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = (32'(ptr) + k) % N;
         if (!any && req[W'(cand)]) begin
            any          = 1'b1;
            gnt[W'(cand)] = 1'b1;
            idx          = W'(cand);
            ptr_nxt      = W'((cand + 1) % N);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr <= '0;
      end else if (any) begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/mr_retire_sched.sv
// In-order retire queue: program-order slot allocation, arbitrated completion,
// oldest-first retirement and whole-queue flush on an excepting retire.
module mr_retire_sched
   import mr_retire_pkg::*;
#(
   parameter int unsigned QDEPTH = RQ_DEPTH,
   parameter int unsigned NREQ   = RQ_NREQ,
   parameter int unsigned PCW    = RQ_PCW,
   parameter int unsigned IDW    = RQ_IDW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alloc_valid,
   input  logic [PCW-1:0]     alloc_pc,
   output logic               alloc_ready,
   output logic [IDW-1:0]     alloc_id,
   input  logic [NREQ-1:0]    cmpl_valid,
   input  logic [NREQ*IDW-1:0] cmpl_id,
   input  logic [NREQ-1:0]    cmpl_exc,
   output logic [NREQ-1:0]    cmpl_ready,
   output logic               retire_valid,
   output logic [IDW-1:0]     retire_id,
   output logic [PCW-1:0]     retire_pc,
   output logic               retire_exc,
   output logic               flush,
   output logic [PCW-1:0]     flush_pc
);

   localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = IDW + 1;

   rq_entry_t       q [QDEPTH];
   logic [IDW-1:0]  head;
   logic [IDW-1:0]  tail;
   logic [CW-1:0]   count;

   logic [NREQ-1:0] gnt;
   logic            gnt_any;
   logic [GW-1:0]   gnt_idx;
   inst_id_t        cmpl_tgt;
   logic            cmpl_exc_g;
   logic            cmpl_ok;
   logic            alloc_fire;
   logic            do_flush;

   mr_rr_arb #(.N(NREQ)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (cmpl_valid),
      .gnt (gnt),
      .any (gnt_any),
      .idx (gnt_idx)
   );

   // Handshakes and retire view are combinational from registered queue state.
   always_comb begin
      retire_valid = q[head].valid & q[head].done;
      retire_id    = head;
      retire_pc    = q[head].pc;
      retire_exc   = retire_valid & q[head].exc;
      do_flush     = retire_valid & retire_exc;
      alloc_ready  = (count < CW'(QDEPTH)) & ~do_flush;
      alloc_id     = tail;
      alloc_fire   = alloc_valid & alloc_ready;
      cmpl_ready   = gnt;
      cmpl_tgt     = cmpl_id[gnt_idx*IDW +: IDW];
      cmpl_exc_g   = cmpl_exc[gnt_idx];
      cmpl_ok      = q[cmpl_tgt].valid & ~q[cmpl_tgt].done;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            q[IDW'(i)] <= '0;
         end
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         flush    <= 1'b0;
         flush_pc <= '0;
      end else begin
         flush <= do_flush;
         if (do_flush) begin
            // Completions granted this cycle are swallowed along with the queue.
            for (int unsigned i = 0; i < QDEPTH; i++) begin
               q[IDW'(i)].valid <= 1'b0;
               q[IDW'(i)].done  <= 1'b0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            flush_pc <= retire_pc;
         end else begin
            if (gnt_any && cmpl_ok) begin
               q[cmpl_tgt].done <= 1'b1;
               q[cmpl_tgt].exc  <= cmpl_exc_g;
            end
            if (retire_valid) begin
               q[head].valid <= 1'b0;
               head          <= head + IDW'(1);
            end
            if (alloc_fire) begin
               q[tail] <= '{valid: 1'b1, done: 1'b0, exc: 1'b0, pc: alloc_pc};
               tail    <= tail + IDW'(1);
            end
            case ({alloc_fire, retire_valid})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: ;
            endcase
         end
      end
   end

   // A completion must target a live, not-yet-completed entry.
   assert property (@(posedge clk) disable iff (!rst) gnt_any |-> cmpl_ok)
      else $error("completion to invalid or already-done entry %0d", cmpl_tgt);

endmodule

// File: tb/tb_mr_retire_sched.sv
// Directed bench for mr_retire_sched with an in-order retire scoreboard.
module tb_mr_retire_sched;

   logic        clk;
   logic        rst;
   logic        alloc_valid;
   logic [31:0] alloc_pc;
   logic        alloc_ready;
   logic [2:0]  alloc_id;
   logic [1:0]  cmpl_valid;
   logic [5:0]  cmpl_id;
   logic [1:0]  cmpl_exc;
   logic [1:0]  cmpl_ready;
   logic        retire_valid;
   logic [2:0]  retire_id;
   logic [31:0] retire_pc;
   logic        retire_exc;
   logic        flush;
   logic [31:0] flush_pc;

   typedef struct packed {
      logic [2:0]  id;
      logic [31:0] pc;
   } sb_t;

   sb_t         sbq[$];
   logic        mexc [8];
   logic        pend;
   logic [31:0] pend_pc;
   int          n_cmp;
   int          n_err;
   int          n_ret;
   int          ret_snap;

   mr_retire_sched dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_valid  (alloc_valid),
      .alloc_pc     (alloc_pc),
      .alloc_ready  (alloc_ready),
      .alloc_id     (alloc_id),
      .cmpl_valid   (cmpl_valid),
      .cmpl_id      (cmpl_id),
      .cmpl_exc     (cmpl_exc),
      .cmpl_ready   (cmpl_ready),
      .retire_valid (retire_valid),
      .retire_id    (retire_id),
      .retire_pc    (retire_pc),
      .retire_exc   (retire_exc),
      .flush        (flush),
      .flush_pc     (flush_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Negedge monitor: pops the scoreboard on every retire and tracks the flush pulse.
   task automatic mon();
      sb_t  e;
      logic nxt;
      @(negedge clk);
      check("flush", flush, pend);
      if (pend) check("flush_pc", flush_pc, pend_pc);
      nxt = 1'b0;
      if (retire_valid) begin
         n_ret++;
         if (sbq.size() == 0) begin
            check("retire_unexpected", retire_valid, 0);
         end else begin
            e = sbq.pop_front();
            check("sb_retire_id", retire_id, e.id);
            check("sb_retire_pc", retire_pc, e.pc);
            check("sb_retire_exc", retire_exc, mexc[e.id]);
            if (mexc[e.id]) begin
               sbq.delete();
               nxt     = 1'b1;
               pend_pc = e.pc;
            end
         end
      end
      pend = nxt;
   endtask

   task automatic tick();
      mon();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      alloc_valid = 1'b0;
      cmpl_valid  = '0;
      sbq.delete();
      pend        = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic chk_reset(input string tag);
      #1;
      check({tag, "_alloc_ready"}, alloc_ready, 1);
      check({tag, "_alloc_id"}, alloc_id, 0);
      check({tag, "_cmpl_ready"}, cmpl_ready, 0);
      check({tag, "_retire_valid"}, retire_valid, 0);
      check({tag, "_flush"}, flush, 0);
      check({tag, "_flush_pc"}, flush_pc, 0);
   endtask

   task automatic alloc(input logic [31:0] pc, input logic [2:0] exp_id);
      sb_t e;
      alloc_valid = 1'b1;
      alloc_pc    = pc;
      #1;
      check("alloc_ready", alloc_ready, 1);
      check("alloc_id", alloc_id, exp_id);
      e.id = exp_id;
      e.pc = pc;
      sbq.push_back(e);
      mexc[exp_id] = 1'b0;
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic cmpl(input logic [1:0] v, input logic [2:0] i0, input logic [2:0] i1,
                       input logic [1:0] e, input logic [1:0] exp_g, input string tag);
      cmpl_valid = v;
      cmpl_id    = {i1, i0};
      cmpl_exc   = e;
      #1;
      check(tag, cmpl_ready, exp_g);
      if (exp_g[0]) mexc[i0] = e[0];
      if (exp_g[1]) mexc[i1] = e[1];
      tick();
      cmpl_valid = '0;
   endtask

   initial begin
      rst = 1'b0; alloc_valid = 1'b0; alloc_pc = '0;
      cmpl_valid = '0; cmpl_id = '0; cmpl_exc = '0;
      pend = 1'b0; pend_pc = '0;
      n_cmp = 0; n_err = 0; n_ret = 0; ret_snap = 0;
      for (int i = 0; i < 8; i++) mexc[i] = 1'b0;

      do_reset();
      chk_reset("rst1");

      // Fill the queue.
      for (int i = 0; i < 8; i++) alloc(32'h100 + 32'(4 * i), 3'(i));
      #1 check("full_ready", alloc_ready, 0);

      // Out-of-order completion, in-order retire.
      cmpl(2'b10, 3'd0, 3'd2, 2'b00, 2'b10, "gnt_id2");
      #1 check("no_retire_a", retire_valid, 0);
      cmpl(2'b01, 3'd1, 3'd0, 2'b00, 2'b01, "gnt_id1");
      #1 check("no_retire_b", retire_valid, 0);
      cmpl(2'b10, 3'd0, 3'd0, 2'b00, 2'b10, "gnt_id0");
      check("n_ret_pre", n_ret, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("ret_valid", retire_valid, 1);
         check("ret_id", retire_id, 3'(k));
         check("ret_pc", retire_pc, 32'h100 + 32'(4 * k));
         tick();
      end
      #1 check("ret_stop", retire_valid, 0);
      check("n_ret_post", n_ret, 3);

      // Refill (tail wraps) and exercise round-robin.
      for (int i = 0; i < 3; i++) alloc(32'h120 + 32'(4 * i), 3'(i));
      #1 check("full_ready2", alloc_ready, 0);
      cmpl(2'b11, 3'd3, 3'd6, 2'b00, 2'b01, "rr0");
      cmpl(2'b11, 3'd4, 3'd6, 2'b00, 2'b10, "rr1");
      cmpl(2'b11, 3'd4, 3'd7, 2'b00, 2'b01, "rr2");
      cmpl(2'b11, 3'd5, 3'd7, 2'b00, 2'b10, "rr3");
      cmpl(2'b10, 3'd0, 3'd5, 2'b00, 2'b10, "lone0");
      cmpl(2'b10, 3'd0, 3'd1, 2'b00, 2'b10, "lone1");
      tick();
      tick();
      #1 check("head0_wait", retire_valid, 0);

      // Full queue, retire frees a slot; no same-cycle reuse.
      for (int i = 3; i < 8; i++) alloc(32'h140 + 32'(4 * (i - 3)), 3'(i));
      alloc_valid = 1'b1;
      alloc_pc    = 32'h180;
      #1 check("full_hold", alloc_ready, 0);
      cmpl(2'b01, 3'd0, 3'd0, 2'b00, 2'b01, "gnt_head");
      #1;
      check("wrap_ret_valid", retire_valid, 1);
      check("wrap_ret_id", retire_id, 0);
      check("wrap_no_bypass", alloc_ready, 0);
      tick();
      #1;
      check("wrap_ready", alloc_ready, 1);
      check("wrap_id", alloc_id, 0);
      sbq.push_back('{id: 3'd0, pc: 32'h180});
      mexc[0] = 1'b0;
      tick();
      alloc_valid = 1'b0;

      // Exception retire and flush.
      do_reset();
      chk_reset("rst2");
      alloc(32'h200, 3'd0);
      alloc(32'h204, 3'd1);
      alloc(32'h208, 3'd2);
      cmpl(2'b01, 3'd1, 3'd0, 2'b01, 2'b01, "gnt_exc");
      cmpl(2'b01, 3'd0, 3'd0, 2'b00, 2'b01, "gnt_id0b");
      #1;
      check("exc_r0_valid", retire_valid, 1);
      check("exc_r0_id", retire_id, 0);
      check("exc_r0_exc", retire_exc, 0);
      tick();
      #1;
      check("exc_r1_valid", retire_valid, 1);
      check("exc_r1_id", retire_id, 1);
      check("exc_r1_exc", retire_exc, 1);
      check("exc_alloc_block", alloc_ready, 0);
      cmpl(2'b10, 3'd0, 3'd2, 2'b00, 2'b10, "gnt_flushcyc");
      #1;
      check("flush_pulse", flush, 1);
      check("flush_pc_val", flush_pc, 32'h204);
      check("post_flush_ready", alloc_ready, 1);
      check("post_flush_id", alloc_id, 0);
      check("post_flush_rv", retire_valid, 0);
      tick();
      #1 check("flush_one_cycle", flush, 0);
      tick();
      tick();
      #1;
      check("flush_pc_held", flush_pc, 32'h204);
      check("id2_dropped", retire_valid, 0);
      alloc(32'h300, 3'd0);

      // Reset with entries in flight.
      for (int i = 1; i < 5; i++) alloc(32'h300 + 32'(4 * i), 3'(i));
      cmpl(2'b01, 3'd1, 3'd0, 2'b00, 2'b01, "gnt6_1");
      cmpl(2'b10, 3'd0, 3'd2, 2'b00, 2'b10, "gnt6_2");
      cmpl(2'b01, 3'd3, 3'd0, 2'b00, 2'b01, "gnt6_3");
      cmpl(2'b10, 3'd0, 3'd4, 2'b00, 2'b10, "gnt6_4");
      ret_snap = n_ret;
      rst        = 1'b0;
      cmpl_valid = 2'b01;
      cmpl_id    = 6'd0;
      sbq.delete();
      pend = 1'b0;
      tick();
      rst        = 1'b1;
      cmpl_valid = '0;
      chk_reset("rst3");
      repeat (4) tick();
      check("no_stale_retire", n_ret, ret_snap);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
